// File: rtl/issue_pkg.sv
// issue_pkg: instruction field positions, state encoding and register decode for the issue unit
package issue_pkg;
  localparam int OPC = 26, RD = 21, RS = 16, RT = 11, IMM = 0;
  localparam logic [5:0] OP_NOP = 6'd0;
  localparam int DSRC = 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [4:0] rd, rs, rt;
    logic we, rt_used;
    logic [15:0] imm;
  } regs_t;
  function automatic regs_t decode(input logic [31:0] w);
    regs_t r;
    r.rd = w[RD+:5];
    r.rs = w[RS+:5];
    r.rt = w[RT+:5];
    r.we = w[OPC+:6] != OP_NOP;
    r.rt_used = !w[OPC+DSRC];
    r.imm = w[IMM+:16];
    return r;
  endfunction
endpackage

// File: rtl/instr_issue_unit_hazard_check.sv
// hazard_check: flags a read-after-write conflict between a candidate and recently issued writers
module hazard_check
  import issue_pkg::*;
#(
  parameter int H = 2
) (
  input  logic [31:0]    cand,
  input  logic [H*5-1:0] hist_rd,
  input  logic [H-1:0]   hist_we,
  output logic           stall
);
  regs_t c;
  logic unused_bits;
  assign c = decode(cand);
  assign unused_bits = ^{c.rd, c.imm};
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < H; i++)
      stall = stall | (hist_we[i] & ((hist_rd[i*5+:5] == c.rs) | (c.rt_used & (hist_rd[i*5+:5] == c.rt))));
    stall = stall & c.we;
  end
endmodule

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program store that feeds the pipeline one instruction or hazard NOP per cycle
module instr_issue_unit
  import issue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int HAZARD_DIST = 3,
  parameter int DRAIN_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [31:0]   InstrOut,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);
  localparam int H = HAZARD_DIST - 1;
  localparam int HW = H * 5;
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t state, state_n;
  logic [AW:0] len, len_n;
  logic [AW-1:0] pc_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic prime, prime_n, idle, stall, issue, cand_we;
  logic [HW-1:0] hist_rd, hist_rd_n;
  logic [H-1:0] hist_we, hist_we_n;
  logic [31:0] instr_n, cand;
  logic [15:0] stall_n;
  logic [31:0] mem [DEPTH];
  assign cand = mem[pc];
  assign cand_we = cand[OPC+:6] != OP_NOP;
  assign idle = (state == IDLE) || (state == DONE);
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = state == DONE;
  assign issue = (state == RUN) && !prime && !stall;
  hazard_check #(.H(H)) u_hazard (
    .cand(cand),
    .hist_rd(hist_rd),
    .hist_we(hist_we),
    .stall(stall)
  );
  always_comb begin
    state_n = state;
    len_n = len;
    pc_n = pc;
    drain_n = drain_cnt;
    prime_n = prime;
    hist_rd_n = hist_rd;
    hist_we_n = hist_we;
    instr_n = 32'h0;
    stall_n = stall_cnt;
    if (idle && start) begin
      len_n = prog_len;
      pc_n = '0;
      drain_n = '0;
      prime_n = 1'b1;
      hist_rd_n = '0;
      hist_we_n = '0;
      stall_n = 16'd0;
      state_n = (prog_len == '0) ? DRAIN : RUN;
    end else if (state == RUN) begin
      prime_n = 1'b0;
      hist_rd_n = HW'({hist_rd, cand[RD+:5]});
      hist_we_n = H'({hist_we, issue & cand_we});
      instr_n = issue ? cand : 32'h0;
      pc_n = issue ? pc + 1'b1 : pc;
      stall_n = (!prime && stall && !(&stall_cnt)) ? stall_cnt + 16'd1 : stall_cnt;
      state_n = (issue && (({1'b0, pc} + 1'b1) == len)) ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      drain_n = drain_cnt + 1'b1;
      state_n = (drain_cnt == DW'(DRAIN_CYC - 1)) ? DONE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      pc <= '0;
      drain_cnt <= '0;
      prime <= 1'b0;
      hist_rd <= '0;
      hist_we <= '0;
      InstrOut <= 32'h0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_n;
      len <= len_n;
      pc <= pc_n;
      drain_cnt <= drain_n;
      prime <= prime_n;
      hist_rd <= hist_rd_n;
      hist_we <= hist_we_n;
      InstrOut <= instr_n;
      stall_cnt <= stall_n;
    end
  end
  always_ff @(posedge clk) begin
    if (load_en && idle) mem[load_addr] <= load_data;
  end
  assert property (@(posedge clk) disable iff (rst) !(idle && start && load_en && (load_addr == '0)));
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: scoreboard bench replaying directed programs against hand-derived issue traces
module tb_instr_issue_unit;
  logic clk = 1'b0, rst = 1'b1, load_en = 1'b0, start = 1'b0;
  logic [3:0] load_addr = 4'd0;
  logic [31:0] load_data = 32'h0;
  logic [4:0] prog_len = 5'd0;
  logic [31:0] InstrOut;
  logic [3:0] pc;
  logic busy, done;
  logic [15:0] stall_cnt;
  typedef struct {
    logic [31:0] instr;
    logic busy, done;
    logic [3:0] pc;
    logic [15:0] stall;
  } exp_t;
  exp_t q[$];
  logic [31:0] plan[$];
  int total = 0, bad = 0, cyc = 0;
  instr_issue_unit dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .prog_len(prog_len), .InstrOut(InstrOut), .pc(pc), .busy(busy),
    .done(done), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
    return {op[5:0], rd[4:0], rs[4:0], rt[4:0], 11'd0};
  endfunction
  task automatic push(input logic [31:0] i, input int b, input int d, input int p, input int s);
    exp_t e;
    e.instr = i;
    e.busy = b[0];
    e.done = d[0];
    e.pc = p[3:0];
    e.stall = s[15:0];
    q.push_back(e);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] w);
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, a, w);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr", InstrOut, e.instr);
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("pc", 32'(pc), 32'(e.pc));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
      end
    end
  end
  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a[3:0];
    load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask
  task automatic wait_q;
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout left=%0d", q.size());
      q.delete();
    end
  endtask
  // plan lists what appears on InstrOut per RUN edge after the priming edge; 0 marks a hazard bubble
  task automatic start_run(input int len);
    int pcv = 0, st = 0;
    @(negedge clk);
    start = 1'b1;
    prog_len = len[4:0];
    push(32'h0, 1, 0, 0, 0);
    if (len > 0) begin
      push(32'h0, 1, 0, 0, 0);
      foreach (plan[i]) begin
        if (plan[i] == 32'h0) st++;
        else pcv = (pcv + 1) % 16;
        push(plan[i], 1, 0, pcv, st);
      end
    end
    repeat (2) push(32'h0, 1, 0, pcv, st);
    repeat (2) push(32'h0, 0, 1, pcv, st);
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    push(32'h0, 0, 0, 0, 0);
    push(32'h0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_q();
    for (int k = 0; k < 4; k++) load(k, mk(1, k + 1, 10, 11));
    plan.delete();
    for (int k = 0; k < 4; k++) plan.push_back(mk(1, k + 1, 10, 11));
    start_run(4);
    wait_q();
    load(0, mk(1, 1, 2, 3));
    load(1, mk(1, 5, 1, 6));
    plan.delete();
    plan.push_back(mk(1, 1, 2, 3));
    plan.push_back(32'h0);
    plan.push_back(32'h0);
    plan.push_back(mk(1, 5, 1, 6));
    start_run(2);
    wait_q();
    load(1, mk(1, 4, 5, 6));
    load(2, mk(2, 7, 8, 1));
    plan.delete();
    plan.push_back(mk(1, 1, 2, 3));
    plan.push_back(mk(1, 4, 5, 6));
    plan.push_back(32'h0);
    plan.push_back(mk(2, 7, 8, 1));
    start_run(3);
    wait_q();
    load(2, mk(10, 7, 8, 1));
    plan.delete();
    plan.push_back(mk(1, 1, 2, 3));
    plan.push_back(mk(1, 4, 5, 6));
    plan.push_back(mk(10, 7, 8, 1));
    start_run(3);
    wait_q();
    plan.delete();
    start_run(0);
    wait_q();
    for (int k = 0; k < 16; k++) load(k, mk(1, 16 + k, 1, 2));
    plan.delete();
    for (int k = 0; k < 16; k++) plan.push_back(mk(1, 16 + k, 1, 2));
    start_run(16);
    load(0, 32'hDEADBEEF);
    wait_q();
    plan.delete();
    plan.push_back(mk(1, 16, 1, 2));
    start_run(1);
    wait_q();
    for (int k = 0; k < 4; k++) load(k, mk(1, k + 1, 10, 11));
    @(negedge clk);
    start = 1'b1;
    prog_len = 5'd4;
    push(32'h0, 1, 0, 0, 0);
    push(32'h0, 1, 0, 0, 0);
    push(mk(1, 1, 10, 11), 1, 0, 1, 0);
    push(mk(1, 2, 10, 11), 1, 0, 2, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push(32'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_q();
    plan.delete();
    for (int k = 0; k < 4; k++) plan.push_back(mk(1, k + 1, 10, 11));
    start_run(4);
    wait_q();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
